// File: rtl/physics_pkg.sv
// Shared rigid-body types for the physics pipeline: fixed-point field widths,
// the packed body record and the pair-scanner state encoding.
package physics_pkg;

    localparam int SIZE_INT_W  = 8;
    localparam int SIZE_FRAC_W = 0;
    localparam int SIZE_W      = SIZE_INT_W + SIZE_FRAC_W;
    localparam int POS_INT_W   = 7;
    localparam int POS_FRAC_W  = 25;
    localparam int POS_W       = POS_INT_W + POS_FRAC_W;
    localparam int VEL_INT_W   = 6;
    localparam int VEL_FRAC_W  = 26;
    localparam int VEL_W       = VEL_INT_W + VEL_FRAC_W;
    localparam int UV_INT_W    = 2;
    localparam int UV_FRAC_W   = 14;
    localparam int UV_W        = UV_INT_W + UV_FRAC_W;

    typedef struct packed {
        logic        [SIZE_W-1:0] width;
        logic        [SIZE_W-1:0] height;
        logic signed [POS_W-1:0]  pos_x;
        logic signed [POS_W-1:0]  pos_y;
        logic signed [VEL_W-1:0]  vel_x;
        logic signed [VEL_W-1:0]  vel_y;
        logic signed [UV_W-1:0]   u_x;
        logic signed [UV_W-1:0]   u_y;
        logic signed [UV_W-1:0]   v_x;
        logic signed [UV_W-1:0]   v_y;
    } body_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        CAPT_A = 3'd2,
        LOAD_B = 3'd3,
        CAPT_B = 3'd4,
        EVAL   = 3'd5,
        EMIT   = 3'd6,
        DONE   = 3'd7
    } scan_state_e;

endpackage

// File: rtl/collision_pair_scanner_if.sv
// Pair-event stream from the scanner to the physics response stage.
interface collision_pair_scanner_if #(
    parameter int IDX_W = 3
);
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_a_idx;
    logic [IDX_W-1:0] pair_b_idx;
    logic             pair_hit;

    modport master (output pair_valid, output pair_a_idx, output pair_b_idx,
                    output pair_hit, input pair_ready);
    modport slave  (input pair_valid, input pair_a_idx, input pair_b_idx,
                    input pair_hit, output pair_ready);
endinterface

// File: rtl/collision_pair_counter.sv
// Outer/inner body indices for the unordered-pair sweep; also exposes the
// next-cycle indices so the scanner can register its RAM address.
module collision_pair_counter #(
    parameter  int NUM_BODIES = 8,
    localparam int IDX_W      = $clog2(NUM_BODIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_load_j,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_i_idx,
    output logic [IDX_W-1:0] o_j_idx,
    output logic [IDX_W-1:0] o_i_next,
    output logic [IDX_W-1:0] o_j_next,
    output logic             o_last_j,
    output logic             o_last_pair
);

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BODIES - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BODIES - 2);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] w_i_next;
    logic [IDX_W-1:0] w_j_next;
    logic             w_last_j;
    logic             w_last_i;

    assign w_last_j = (r_j == LAST_J);
    assign w_last_i = (r_i == LAST_I);

    // Inner index runs first; the outer one only moves once the row is exhausted
    always_comb begin
        w_i_next = r_i;
        w_j_next = r_j;
        if (i_clear) begin
            w_i_next = {IDX_W{1'b0}};
            w_j_next = {IDX_W{1'b0}};
        end else if (i_load_j) begin
            w_j_next = r_i + ONE;
        end else if (i_advance) begin
            if (!w_last_j) begin
                w_j_next = r_j + ONE;
            end else if (!w_last_i) begin
                w_i_next = r_i + ONE;
            end else begin
                w_i_next = r_i;
            end
        end else begin
            w_j_next = r_j;
        end
    end

    // Index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= {IDX_W{1'b0}};
            r_j <= {IDX_W{1'b0}};
        end else begin
            r_i <= w_i_next;
            r_j <= w_j_next;
        end
    end

    assign o_i_idx     = r_i;
    assign o_j_idx     = r_j;
    assign o_i_next    = w_i_next;
    assign o_j_next    = w_j_next;
    assign o_last_j    = w_last_j;
    assign o_last_pair = w_last_j & w_last_i;

endmodule

// File: rtl/collision_pair_scanner.sv
// Sweeps every unordered body pair through the external rectangle detector.
// Define SCAN_EMIT_ALL_PAIRS_EN to emit miss pairs as events too.
module collision_pair_scanner
    import physics_pkg::*;
#(
    parameter  int NUM_BODIES = 8,
    localparam int IDX_W      = $clog2(NUM_BODIES)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      body_rd_en,
    output logic [IDX_W-1:0]          body_rd_idx,
    input  body_t                     body_rd_data,
    output body_t                     det_body_a,
    output body_t                     det_body_b,
    input  logic                      det_is_collision,
    collision_pair_scanner_if.master  pair_if,
    output logic [NUM_BODIES-1:0]     collide_mask
);

    localparam logic [NUM_BODIES-1:0] BIT0 = {{(NUM_BODIES-1){1'b0}}, 1'b1};

    scan_state_e             r_state;
    scan_state_e             w_state_next;
    scan_state_e             w_after_pair;
    logic                    w_clear;
    logic                    w_load_j;
    logic                    w_advance;
    logic [IDX_W-1:0]        w_i_idx;
    logic [IDX_W-1:0]        w_j_idx;
    logic [IDX_W-1:0]        w_i_next;
    logic [IDX_W-1:0]        w_j_next;
    logic                    w_last_j;
    logic                    w_last_pair;
    logic [NUM_BODIES-1:0]   w_pair_bits;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_rd_en;
    logic [IDX_W-1:0]        r_rd_idx;
    logic                    r_pair_valid;
    logic                    r_hit;
    body_t                   r_body_a;
    body_t                   r_body_b;
    logic [NUM_BODIES-1:0]   r_work_mask;
    logic [NUM_BODIES-1:0]   r_collide_mask;

    collision_pair_counter #(.NUM_BODIES(NUM_BODIES)) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_load_j    (w_load_j),
        .i_advance   (w_advance),
        .o_i_idx     (w_i_idx),
        .o_j_idx     (w_j_idx),
        .o_i_next    (w_i_next),
        .o_j_next    (w_j_next),
        .o_last_j    (w_last_j),
        .o_last_pair (w_last_pair)
    );

    assign w_after_pair = !w_last_j ? LOAD_B : (!w_last_pair ? LOAD_A : DONE);
    assign w_pair_bits  = (BIT0 << w_i_idx) | (BIT0 << w_j_idx);

    // Next-state and counter control
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load_j     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD_A;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOAD_A: w_state_next = CAPT_A;
            CAPT_A: begin
                w_state_next = LOAD_B;
                w_load_j     = 1'b1;
            end
            LOAD_B: w_state_next = CAPT_B;
            CAPT_B: w_state_next = EVAL;
            EVAL: begin
`ifdef SCAN_EMIT_ALL_PAIRS_EN
                w_state_next = EMIT;
`else
                if (det_is_collision) begin
                    w_state_next = EMIT;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = w_after_pair;
                end
`endif
            end
            EMIT: begin
                if (pair_if.pair_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = w_after_pair;
                end else begin
                    w_state_next = EMIT;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, registered status/strobe outputs and captured body data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rd_en        <= 1'b0;
            r_rd_idx       <= {IDX_W{1'b0}};
            r_pair_valid   <= 1'b0;
            r_hit          <= 1'b0;
            r_body_a       <= '0;
            r_body_b       <= '0;
            r_work_mask    <= {NUM_BODIES{1'b0}};
            r_collide_mask <= {NUM_BODIES{1'b0}};
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next != IDLE);
            r_done       <= (w_state_next == DONE);
            r_rd_en      <= (w_state_next == LOAD_A) || (w_state_next == LOAD_B);
            r_rd_idx     <= (w_state_next == LOAD_A) ? w_i_next :
                            (w_state_next == LOAD_B) ? w_j_next : {IDX_W{1'b0}};
            r_pair_valid <= (w_state_next == EMIT);
            if (r_state == CAPT_A) r_body_a <= body_rd_data;
            if (r_state == CAPT_B) r_body_b <= body_rd_data;
            if (r_state == EVAL)   r_hit    <= det_is_collision;
            if (w_clear) begin
                r_work_mask <= {NUM_BODIES{1'b0}};
            end else if ((r_state == EVAL) && det_is_collision) begin
                r_work_mask <= r_work_mask | w_pair_bits;
            end
            // Publishing on entry to DONE makes the mask valid alongside the done pulse
            if (w_state_next == DONE) r_collide_mask <= r_work_mask;
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign body_rd_en         = r_rd_en;
    assign body_rd_idx        = r_rd_idx;
    assign det_body_a         = r_body_a;
    assign det_body_b         = r_body_b;
    assign collide_mask       = r_collide_mask;
    assign pair_if.pair_valid = r_pair_valid;
    assign pair_if.pair_a_idx = w_i_idx;
    assign pair_if.pair_b_idx = w_j_idx;
    assign pair_if.pair_hit   = r_hit;

endmodule
